// File: rtl/integer_division_multistep.sv
// Sequential restoring divider, BITS_PER_CYCLE quotient bits per clock, optional signed mode.
// Results and div_zero are registered and held between done pulses.
// state | meaning
// IDLE  | waiting for start; results held
// CALC  | BITS_PER_CYCLE restoring steps per clock on magnitudes
// FIX   | sign correction, result write, done pulse
module integer_division_multistep #(
  parameter int WIDTH          = 24,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divider,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dvd, r_div, r_rem, r_quo;
  logic             r_sign_q, r_sign_r, r_dz;
  logic             r_done, r_div_zero;
  logic [WIDTH-1:0] r_quotient, r_remainder;

  logic [WIDTH-1:0] w_dvd_abs, w_div_abs;
  logic [WIDTH-1:0] w_rem_n, w_dvd_n, w_quo_n;
  logic [WIDTH:0]   w_sh, w_diff;
  logic             w_div_is_zero, w_last;

  assign w_dvd_abs     = (signed_mode && dividend[WIDTH-1]) ? -dividend : dividend;
  assign w_div_abs     = (signed_mode && divider[WIDTH-1])  ? -divider  : divider;
  assign w_div_is_zero = (divider == '0);
  assign w_last        = (r_cnt == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = w_div_is_zero ? S_FIX : S_CALC;
      end
      S_CALC:  if (w_last) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Chained restoring steps; the extra subtract bit keeps |-2^(WIDTH-1)| exact.
  always_comb begin
    w_rem_n = r_rem;
    w_dvd_n = r_dvd;
    w_quo_n = r_quo;
    w_sh    = '0;
    w_diff  = '0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      w_sh    = {w_rem_n, w_dvd_n[WIDTH-1]};
      w_dvd_n = {w_dvd_n[WIDTH-2:0], 1'b0};
      w_diff  = w_sh - {1'b0, r_div};
      w_rem_n = w_diff[WIDTH] ? w_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
      w_quo_n = {w_quo_n[WIDTH-2:0], ~w_diff[WIDTH]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_dvd       <= '0;
      r_div       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
      r_dz        <= 1'b0;
      r_done      <= 1'b0;
      r_div_zero  <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dvd    <= w_dvd_abs;
            r_div    <= w_div_abs;
            r_sign_q <= signed_mode & (dividend[WIDTH-1] ^ divider[WIDTH-1]);
            r_sign_r <= signed_mode & dividend[WIDTH-1];
            r_dz     <= w_div_is_zero;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
          end
        end
        S_CALC: begin
          r_rem <= w_rem_n;
          r_dvd <= w_dvd_n;
          r_quo <= w_quo_n;
          r_cnt <= r_cnt + CW'(1);
        end
        S_FIX: begin
          r_done     <= 1'b1;
          r_div_zero <= r_dz;
          if (r_dz) begin
            // r_dvd was never shifted, so re-applying the sign restores the raw dividend
            r_quotient  <= '1;
            r_remainder <= r_sign_r ? -r_dvd : r_dvd;
          end else begin
            r_quotient  <= r_sign_q ? -r_quo : r_quo;
            r_remainder <= r_sign_r ? -r_rem : r_rem;
          end
        end
        default: ;
      endcase
    end
  end

  assign done      = r_done;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_integer_division_multistep.sv
// Bench for integer_division_multistep: six configurations share one stimulus stream and are
// checked every cycle against an arithmetic/latency model, plus literal checks on the 16/2 instance.
module tb_integer_division_multistep;

  localparam int NI = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tb_start = 1'b0;
  logic        tb_sgn = 1'b0;
  logic [23:0] tb_a = '0;
  logic [23:0] tb_b = '0;
  logic        chk_en = 1'b0;

  logic [NI-1:0] o_busy, o_done, o_dz;
  logic [23:0]   o_q [NI];
  logic [23:0]   o_r [NI];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  function automatic int wid(input int g);
    return (g < 3) ? 16 : 24;
  endfunction

  function automatic int bpc(input int g);
    return 1 << (g % 3);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int W = (g < 3) ? 16 : 24;
    localparam int B = 1 << (g % 3);
    logic [W-1:0] q, r;
    logic         busy, done, dz;
    integer_division_multistep #(.WIDTH(W), .BITS_PER_CYCLE(B)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (tb_start),
      .signed_mode(tb_sgn),
      .dividend   (tb_a[W-1:0]),
      .divider    (tb_b[W-1:0]),
      .busy       (busy),
      .done       (done),
      .quotient   (q),
      .remainder  (r),
      .div_zero   (dz)
    );
    assign o_q[g]    = 24'(q);
    assign o_r[g]    = 24'(r);
    assign o_busy[g] = busy;
    assign o_done[g] = done;
    assign o_dz[g]   = dz;
  end

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (inst %0d) t=%0t: got 0x%0h, expected 0x%0h", nm, g, $time, act, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero in signed mode.
  function automatic void ref_div(input int w, input bit sgn, input logic [23:0] a_in,
                                  input logic [23:0] b_in, output logic [23:0] q,
                                  output logic [23:0] r, output bit dz);
    longint mask, a, b, qq, rr;
    mask = (longint'(1) << w) - 1;
    a    = longint'(a_in) & mask;
    b    = longint'(b_in) & mask;
    dz   = (b == 0);
    if (dz) begin
      qq = mask;
      rr = a;
    end else begin
      if (sgn) begin
        if (a[w-1]) a = a - (longint'(1) << w);
        if (b[w-1]) b = b - (longint'(1) << w);
      end
      qq = a / b;
      rr = a % b;
    end
    q = 24'(qq & mask);
    r = 24'(rr & mask);
  endfunction

  int          m_cnt [NI];
  logic        m_done [NI];
  logic        m_dz [NI];
  logic [23:0] m_q [NI];
  logic [23:0] m_r [NI];
  logic [23:0] p_q [NI];
  logic [23:0] p_r [NI];
  logic        p_dz [NI];

  // Latency model: an accepted op stays busy for WIDTH/BPC+1 edges (1 on divide-by-zero).
  always @(posedge clk) begin
    logic [23:0] mq, mr;
    bit          mdz;
    for (int g = 0; g < NI; g++) begin
      if (rst) begin
        m_cnt[g]  <= 0;
        m_done[g] <= 1'b0;
        m_dz[g]   <= 1'b0;
        m_q[g]    <= '0;
        m_r[g]    <= '0;
      end else begin
        m_done[g] <= 1'b0;
        if (m_cnt[g] == 0) begin
          if (tb_start) begin
            ref_div(wid(g), tb_sgn, tb_a, tb_b, mq, mr, mdz);
            p_q[g]   <= mq;
            p_r[g]   <= mr;
            p_dz[g]  <= mdz;
            m_cnt[g] <= mdz ? 1 : wid(g) / bpc(g) + 1;
          end
        end else begin
          m_cnt[g] <= m_cnt[g] - 1;
          if (m_cnt[g] == 1) begin
            m_done[g] <= 1'b1;
            m_q[g]    <= p_q[g];
            m_r[g]    <= p_r[g];
            m_dz[g]   <= p_dz[g];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int g = 0; g < NI; g++) begin
        chk("busy", g, 32'(o_busy[g]), 32'(m_cnt[g] != 0));
        chk("done", g, 32'(o_done[g]), 32'(m_done[g]));
        chk("quotient", g, 32'(o_q[g]), 32'(m_q[g]));
        chk("remainder", g, 32'(o_r[g]), 32'(m_r[g]));
        chk("div_zero", g, 32'(o_dz[g]), 32'(m_dz[g]));
      end
    end
  end

  function automatic bit any_busy();
    for (int g = 0; g < NI; g++) if (m_cnt[g] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (any_busy() && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", -1, 32'(any_busy()), 32'd0);
    @(negedge clk);
  endtask

  // One operation; literal expectations are for the WIDTH=16, BITS_PER_CYCLE=2 instance.
  task automatic op(input string nm, input bit sgn, input logic [23:0] a, input logic [23:0] b,
                    input logic [15:0] eq, input logic [15:0] er, input bit edz, input int elat);
    int lat, nb;
    @(negedge clk);
    tb_sgn = sgn; tb_a = a; tb_b = b; tb_start = 1'b1;
    @(negedge clk);
    tb_start = 1'b0;
    lat = 0; nb = 0;
    while (!o_done[1] && lat < 100) begin
      if (o_busy[1]) nb++;
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, 1, 32'(lat), 32'(elat));
    chk({nm, "_busy_cycles"}, 1, 32'(nb), 32'(elat));
    chk({nm, "_q"}, 1, 32'(o_q[1]), 32'(eq));
    chk({nm, "_r"}, 1, 32'(o_r[1]), 32'(er));
    chk({nm, "_dz"}, 1, 32'(o_dz[1]), 32'(edz));
    wait_idle();
  endtask

  initial begin
    int prev, n_done;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_busy", 1, 32'(o_busy[1]), 32'd0);
    chk("reset_q", 1, 32'(o_q[1]), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    op("u1000_7", 1'b0, 24'h0003E8, 24'h000007, 16'h008E, 16'h0006, 1'b0, 9);
    op("s_m7_2",  1'b1, 24'h00FFF9, 24'h000002, 16'hFFFD, 16'hFFFF, 1'b0, 9);
    op("u_m7_2",  1'b0, 24'h00FFF9, 24'h000002, 16'h7FFC, 16'h0001, 1'b0, 9);
    op("u_div0",  1'b0, 24'h001234, 24'h000000, 16'hFFFF, 16'h1234, 1'b1, 1);
    op("s_div0",  1'b1, 24'h001234, 24'h000000, 16'hFFFF, 16'h1234, 1'b1, 1);
    op("clr_dz",  1'b0, 24'h0003E8, 24'h000007, 16'h008E, 16'h0006, 1'b0, 9);
    op("s_ovf",   1'b1, 24'h008000, 24'h00FFFF, 16'h8000, 16'h0000, 1'b0, 9);
    op("u_max_1", 1'b0, 24'h00FFFF, 24'h000001, 16'hFFFF, 16'h0000, 1'b0, 9);

    // start and operand changes during CALC are ignored; held results stay put
    @(negedge clk);
    tb_sgn = 1'b0; tb_a = 24'h0003E8; tb_b = 24'h000007; tb_start = 1'b1;
    @(negedge clk);
    tb_start = 1'b0;
    repeat (2) @(negedge clk);
    tb_a = 24'h001234; tb_b = 24'h000000; tb_sgn = 1'b1; tb_start = 1'b1;
    @(negedge clk);
    tb_start = 1'b0;
    chk("mid_busy", 1, 32'(o_busy[1]), 32'd1);
    chk("mid_held_q", 1, 32'(o_q[1]), 32'h0000FFFF);
    wait_idle();
    chk("mid_final_q", 1, 32'(o_q[1]), 32'h008E);
    chk("mid_final_r", 1, 32'(o_r[1]), 32'h0006);

    // reset in the fourth CALC cycle discards the operation
    @(negedge clk);
    tb_sgn = 1'b0; tb_a = 24'h0003E8; tb_b = 24'h000007; tb_start = 1'b1;
    @(negedge clk);
    tb_start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 1, 32'(o_busy[1]), 32'd0);
    chk("rst_q", 1, 32'(o_q[1]), 32'd0);
    chk("rst_r", 1, 32'(o_r[1]), 32'd0);
    n_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (o_done[1]) n_done++;
    end
    chk("rst_no_done", 1, 32'(n_done), 32'd0);
    op("after_rst", 1'b0, 24'h0003E8, 24'h000007, 16'h008E, 16'h0006, 1'b0, 9);

    // start held high: one operation every N+2 cycles
    @(negedge clk);
    tb_sgn = 1'b0; tb_a = 24'h0003E8; tb_b = 24'h000007; tb_start = 1'b1;
    prev = -1; n_done = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (o_done[1]) begin
        if (prev >= 0) chk("b2b_period", 1, 32'(cyc - prev), 32'd10);
        prev = cyc;
        n_done++;
      end
    end
    chk("b2b_count", 1, 32'(n_done), 32'd4);
    tb_start = 1'b0;
    wait_idle();

    // random sweep, all configurations checked by the model
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      tb_sgn = 1'($urandom_range(0, 1));
      tb_a   = 24'($urandom);
      case ($urandom_range(0, 5))
        0:       tb_b = 24'($urandom_range(0, 15));
        1:       tb_b = 24'hFFFFFF;
        2:       tb_b = 24'h800000;
        default: tb_b = 24'($urandom);
      endcase
      if (i % 17 == 0) tb_a = 24'h808000;
      tb_start = 1'b1;
      @(negedge clk);
      tb_start = 1'b0;
      wait_idle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
